// File: rtl/pq_pkg.sv
// pq_pkg: shared widths, entry/slot types and the priority compare used by the sorter cells
package pq_pkg;
  localparam int KEY_WIDTH = 8;
  localparam int VAL_WIDTH = 8;
  typedef struct packed {
    logic [KEY_WIDTH-1:0] key;
    logic [VAL_WIDTH-1:0] val;
  } kv_t;
  typedef struct packed {
    logic valid;
    kv_t  kv;
  } slot_t;
  // Keys arrive zero-extended to 64 bits so any key width up to 64 shares one compare.
  // An invalid slot always loses, which makes the first empty slot the natural tail.
  function automatic logic pq_better(logic [63:0] a, logic b_valid, logic [63:0] b, logic min_first);
    return !b_valid || (min_first ? a < b : a > b);
  endfunction
endpackage

// File: rtl/ra_pq_param_cell.sv
// ra_pq_cell: one slot of the sorted shift array; decides its own insert flag and next content
module ra_pq_cell
  import pq_pkg::*;
#(
  parameter int KEY_WIDTH = pq_pkg::KEY_WIDTH,
  parameter int VAL_WIDTH = pq_pkg::VAL_WIDTH,
  parameter int MIN_FIRST = 1,
  localparam int W = KEY_WIDTH + VAL_WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enq,
  input  logic         deq,
  input  logic         ins_above,
  input  logic [W:0]   above,
  input  logic [W:0]   below,
  input  logic [W-1:0] kvi,
  output logic         ins,
  output logic [W:0]   slot
);
  logic [W:0] cand;
  logic [W:0] nxt;
  // With a dequeue the array moves up first, so this slot is judged against what would land here.
  // Once a slot above has taken kvi, everything below moves one place further down.
  always_comb begin
    cand = deq ? below : slot;
    ins  = enq && pq_better(64'(kvi[W-1:VAL_WIDTH]), cand[W], 64'(cand[W-1:VAL_WIDTH]), MIN_FIRST != 0);
    nxt  = ins_above ? (deq ? slot : above) : ins ? {1'b1, kvi} : cand;
  end
  // Slot register: cleared to invalid/zero on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) slot <= '0;
    else slot <= nxt;
  end
endmodule

// File: rtl/ra_pq_param.sv
// ra_pq_param: register-array priority queue, head at slot 0; RA_PQ_REPLACE_EN lets a better entry evict the tail when full
module ra_pq_param
  import pq_pkg::*;
#(
  parameter int KEY_WIDTH = pq_pkg::KEY_WIDTH,
  parameter int VAL_WIDTH = pq_pkg::VAL_WIDTH,
  parameter int DEPTH     = 8,
  parameter int MIN_FIRST = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             enq,
  input  logic                             deq,
  input  logic [KEY_WIDTH+VAL_WIDTH-1:0]   kvi,
  output logic [KEY_WIDTH+VAL_WIDTH-1:0]   kvo,
  output logic                             ovalid,
  output logic                             empty,
  output logic                             full,
  output logic [$clog2(DEPTH+1)-1:0]       count,
  output logic                             overflow,
  output logic                             underflow
);
  localparam int W  = KEY_WIDTH + VAL_WIDTH;
  localparam int CW = $clog2(DEPTH+1);
  logic [W:0]     s [DEPTH+2];
  logic [DEPTH:0] ins_v;
  logic           deq_e;
  logic           enq_e;
  logic           inc;
  logic           dec;
  logic [CW-1:0]  cnt_n;
  assign s[0]       = '0;
  assign s[DEPTH+1] = '0;
  assign ins_v[0]   = 1'b0;
  assign kvo        = s[1][W-1:0];
  assign ovalid     = s[1][W];
  for (genvar i = 0; i < DEPTH; i++) begin : g_cell
    ra_pq_cell #(
      .KEY_WIDTH(KEY_WIDTH),
      .VAL_WIDTH(VAL_WIDTH),
      .MIN_FIRST(MIN_FIRST)
    ) u_cell (
      .clk      (clk),
      .rst_n    (rst_n),
      .enq      (enq_e),
      .deq      (deq_e),
      .ins_above(ins_v[i]),
      .above    (s[i]),
      .below    (s[i+2]),
      .kvi      (kvi),
      .ins      (ins_v[i+1]),
      .slot     (s[i+1])
    );
  end
  // Qualify the controls: a deq on empty does nothing, and a full queue only takes kvi if it may evict the tail.
  always_comb begin
    deq_e = deq && !empty;
`ifdef RA_PQ_REPLACE_EN
    enq_e = enq;
`else
    enq_e = enq && (!full || deq_e);
`endif
    inc   = enq_e && !deq_e && !full;
    dec   = deq_e && !enq_e;
    cnt_n = inc ? count + CW'(1) : dec ? count - CW'(1) : count;
  end
  // Occupancy and status flags, all registered alongside the slots.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      empty     <= 1'b1;
      full      <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      count     <= cnt_n;
      empty     <= cnt_n == '0;
      full      <= cnt_n == CW'(DEPTH);
      overflow  <= enq && full && !deq_e;
      underflow <= deq && empty;
    end
  end
endmodule

// File: tb/tb_ra_pq_param.sv
// tb_ra_pq_param: queue-model check of ra_pq_param, min- and max-first instances side by side
module tb_ra_pq_param;
  typedef logic [15:0] q_t[$];
  logic        clk = 0;
  logic        rst_n = 0;
  logic        enq = 0;
  logic        deq = 0;
  logic [15:0] kvi = 0;
  logic [15:0] kvo0, kvo1;
  logic        ovalid0, empty0, full0, overflow0, underflow0;
  logic        ovalid1, empty1, full1, overflow1, underflow1;
  logic [2:0]  count0, count1;
  int          checks = 0;
  int          errors = 0;
  q_t          m0, m1;
  bit          of0, uf0, of1, uf1;

  always #5 clk = ~clk;

  ra_pq_param #(.DEPTH(4), .MIN_FIRST(1)) dut (
    .clk(clk), .rst_n(rst_n), .enq(enq), .deq(deq), .kvi(kvi), .kvo(kvo0), .ovalid(ovalid0),
    .empty(empty0), .full(full0), .count(count0), .overflow(overflow0), .underflow(underflow0));
  ra_pq_param #(.DEPTH(4), .MIN_FIRST(0)) dut_mx (
    .clk(clk), .rst_n(rst_n), .enq(enq), .deq(deq), .kvi(kvi), .kvo(kvo1), .ovalid(ovalid1),
    .empty(empty1), .full(full1), .count(count1), .overflow(overflow1), .underflow(underflow1));

  function automatic bit better(logic [7:0] a, logic [7:0] b, bit mf);
    return mf ? a < b : a > b;
  endfunction

  function automatic q_t put(q_t q, logic [15:0] kv, bit mf);
    int p;
    p = q.size();
    for (int i = q.size() - 1; i >= 0; i--)
      if (better(kv[15:8], q[i][15:8], mf)) p = i;
    q.insert(p, kv);
    return q;
  endfunction

  function automatic q_t mstep(q_t q, bit e, bit d, logic [15:0] kv, bit mf, output bit of, output bit uf);
    bit was_full;
    was_full = q.size() == 4;
    uf = d && q.size() == 0;
    of = 0;
    if (d && q.size() > 0) void'(q.pop_front());
    if (e) begin
      if (was_full && !d) begin
        of = 1;
`ifdef RA_PQ_REPLACE_EN
        if (better(kv[15:8], q[3][15:8], mf)) begin
          void'(q.pop_back());
          q = put(q, kv, mf);
        end
`endif
      end else q = put(q, kv, mf);
    end
    return q;
  endfunction

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic go(bit e, bit d, logic [15:0] kv);
    enq = e;
    deq = d;
    kvi = kv;
    @(posedge clk);
    #1;
    enq = 0;
    deq = 0;
  endtask

  // Reference model: sorted queues advanced on each clock edge, cleared by reset.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m0.delete();
      m1.delete();
      {of0, uf0, of1, uf1} = '0;
    end else begin
      m0 = mstep(m0, enq, deq, kvi, 1, of0, uf0);
      m1 = mstep(m1, enq, deq, kvi, 0, of1, uf1);
    end
  end

  // Every cycle out of reset, both instances must match their models.
  initial forever begin
    @(negedge clk);
    if (rst_n === 1'b1) begin
      chk("min kvo", kvo0, m0.size() > 0 ? m0[0] : 16'h0);
      chk("min ovalid", ovalid0, m0.size() != 0);
      chk("min empty", empty0, m0.size() == 0);
      chk("min full", full0, m0.size() == 4);
      chk("min count", count0, m0.size());
      chk("min overflow", overflow0, of0);
      chk("min underflow", underflow0, uf0);
      chk("max kvo", kvo1, m1.size() > 0 ? m1[0] : 16'h0);
      chk("max ovalid", ovalid1, m1.size() != 0);
      chk("max empty", empty1, m1.size() == 0);
      chk("max full", full1, m1.size() == 4);
      chk("max count", count1, m1.size());
      chk("max overflow", overflow1, of1);
      chk("max underflow", underflow1, uf1);
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset count", count0, 0);
    chk("reset empty", empty0, 1);
    chk("reset ovalid", ovalid0, 0);
    chk("reset kvo", kvo0, 0);
    @(negedge clk);
    rst_n = 1;
    // head replacement through enq&deq
    go(1, 0, {8'd8, 8'd14});
    chk("t1 kvo", kvo0, {8'd8, 8'd14});
    chk("t1 count", count0, 1);
    go(0, 0, 0);
    go(1, 1, {8'd2, 8'd12});
    chk("t1 swap kvo", kvo0, {8'd2, 8'd12});
    chk("t1 swap count", count0, 1);
    go(0, 1, 0);
    // equal keys leave in arrival order
    go(1, 0, {8'd9, 8'd10});
    go(1, 0, {8'd9, 8'd11});
    go(1, 0, {8'd9, 8'd12});
    chk("t2 val0", kvo0[7:0], 10);
    go(0, 1, 0);
    chk("t2 val1", kvo0[7:0], 11);
    go(0, 1, 0);
    chk("t2 val2", kvo0[7:0], 12);
    go(0, 1, 0);
    chk("t2 empty", empty0, 1);
    chk("t2 ovalid", ovalid0, 0);
    // enq on full without deq
    go(1, 0, {8'd4, 8'd0});
    go(1, 0, {8'd6, 8'd0});
    go(1, 0, {8'd8, 8'd0});
    go(1, 0, {8'd9, 8'd0});
    chk("t3 full", full0, 1);
    go(1, 0, {8'd1, 8'd5});
    chk("t3 overflow", overflow0, 1);
    chk("t3 count", count0, 4);
`ifdef RA_PQ_REPLACE_EN
    chk("t3 kvo", kvo0, {8'd1, 8'd5});
`else
    chk("t3 kvo key", kvo0[15:8], 4);
`endif
    go(0, 0, 0);
    chk("t3 overflow pulse", overflow0, 0);
    repeat (4) go(0, 1, 0);
    // underflow cases
    go(0, 1, 0);
    chk("t4 underflow", underflow0, 1);
    chk("t4 count", count0, 0);
    go(1, 1, {8'd3, 8'd3});
    chk("t4 kvo", kvo0, {8'd3, 8'd3});
    chk("t4 count1", count0, 1);
    chk("t4 underflow2", underflow0, 1);
    go(0, 1, 0);
    // asynchronous reset mid-cycle
    go(1, 0, {8'd5, 8'd1});
    go(1, 0, {8'd6, 8'd2});
    go(1, 0, {8'd7, 8'd3});
    #2 rst_n = 0;
    #1;
    chk("t5 count", count0, 0);
    chk("t5 ovalid", ovalid0, 0);
    chk("t5 kvo", kvo0, 0);
    chk("t5 empty", empty0, 1);
    @(negedge clk);
    rst_n = 1;
    go(1, 0, {8'd5, 8'd1});
    chk("t5 enq", kvo0, {8'd5, 8'd1});
    go(0, 1, 0);
    // max-first ordering
    go(1, 0, {8'd3, 8'd0});
    go(1, 0, {8'd7, 8'd0});
    go(1, 0, {8'd5, 8'd0});
    chk("t6 head", kvo1[15:8], 7);
    chk("t6 not full", full1, 0);
    go(1, 0, {8'd1, 8'd0});
    chk("t6 full", full1, 1);
    chk("t6 count", count1, 4);
    go(0, 1, 0);
    chk("t6 second", kvo1[15:8], 5);
    chk("t6 full drop", full1, 0);
    go(0, 1, 0);
    chk("t6 third", kvo1[15:8], 3);
    go(0, 1, 0);
    go(0, 1, 0);
    // random traffic, small key range for frequent ties
    for (int n = 0; n < 1500; n++)
      go($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45,
         {8'($urandom_range(0, 7)), 8'($urandom_range(0, 255))});
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
